// File: rtl/elevator_call_panel.sv
// Floor call panel: key sync, pending-call latch, door open/dwell/close FSM.
// Optional ELEVATOR_CALL_CANCEL_EN: a second press on a pending floor cancels it.
module elevator_call_panel #(
  parameter int FLOORS = 10,
  parameter int DWELL  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [FLOORS-1:0] key_in,
  input  logic [3:0]        Layer,
  output logic [FLOORS-1:0] buttons,
  output logic              door_open,
  output logic [3:0]        req_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSE
  } state_t;

  localparam logic [3:0] DW1 = 4'(DWELL - 1);

  state_t state, state_nxt;

  logic [FLOORS-1:0] s1, s2, s3;
  logic [FLOORS-1:0] rise, layer_hot;
  logic [FLOORS-1:0] clr, btn_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [3:0]        open_layer, open_layer_nxt;
  logic [1:0]        warm;
  logic              door_nxt;
  logic              layer_ok, hit, rise_here;

  function automatic logic [3:0] popcount(input logic [FLOORS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < FLOORS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // warm masks the bogus s2/s3 edge while the chain refills after reset
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      warm <= 2'd0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign rise      = (warm == 2'd3) ? (s2 & ~s3) : '0;
  assign layer_ok  = int'(Layer) < FLOORS;
  assign layer_hot = layer_ok ? (FLOORS'(1) << Layer) : '0;
  assign hit       = |(buttons & layer_hot);
  assign rise_here = |(rise & layer_hot);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    door_nxt       = door_open;
    open_layer_nxt = open_layer;
    clr            = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nxt      = OPEN;
          door_nxt       = 1'b1;
          cnt_nxt        = DW1;
          open_layer_nxt = Layer;
        end
      end
      OPEN: begin
        if (Layer != open_layer) begin
          state_nxt = IDLE;
          door_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
        end else if (rise_here) begin
          cnt_nxt = DW1;
        end else if (cnt == 4'd0) begin
          state_nxt = CLOSE;
          door_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CLOSE: begin
        state_nxt = IDLE;
        if (!rise_here) clr = layer_hot;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ELEVATOR_CALL_CANCEL_EN
  logic [FLOORS-1:0] cancel;
  // the served floor's own press restarts dwell instead of cancelling
  assign cancel  = rise & buttons &
                   ((state == IDLE) ? {FLOORS{1'b1}} : ~layer_hot);
  assign btn_nxt = ((buttons | rise) & ~cancel) & ~clr;
`else
  assign btn_nxt = (buttons | rise) & ~clr;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      door_open  <= 1'b0;
      open_layer <= 4'd0;
      buttons    <= '0;
      req_cnt    <= 4'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      door_open  <= door_nxt;
      open_layer <= open_layer_nxt;
      buttons    <= btn_nxt;
      req_cnt    <= popcount(btn_nxt);
    end
  end

endmodule
